// File: rtl/mod12_seg_scan.sv
// rtl/mod12_seg_scan.sv - mod-12 count to 2-digit 7-segment scan with wrap/illegal flags.
// Optional: define LEADING_ZERO_BLANK_EN to blank the tens digit for counts 0..9.
module mod12_seg_scan #(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] Count,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       Carry,
  output logic       Borrow,
  output logic       Err
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0] SEG_E   = 7'b1111001;

  typedef enum logic {SCAN_ONES, SCAN_TENS} scan_state_e;

  scan_state_e   state_q, state_d;
  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    count_p_q, count_p_d;
  logic          cap_valid_q, cap_valid_d;
  logic          prev_valid_q, prev_valid_d;
  logic          carry_q, carry_d;
  logic          borrow_q, borrow_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic          err;
  logic          tens;
  logic [3:0]    ones;
  logic [6:0]    seg_raw;
  logic [1:0]    an_raw;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0111111;
      4'd1:    seg_encode = 7'b0000110;
      4'd2:    seg_encode = 7'b1011011;
      4'd3:    seg_encode = 7'b1001111;
      4'd4:    seg_encode = 7'b1100110;
      4'd5:    seg_encode = 7'b1101101;
      4'd6:    seg_encode = 7'b1111101;
      4'd7:    seg_encode = 7'b0000111;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1101111;
      default: seg_encode = SEG_E;
    endcase
  endfunction

  assign err  = count_q[3] & count_q[2];
  assign tens = (count_q >= 4'd10);
  assign ones = tens ? (count_q - 4'd10) : count_q;

  // State register: all flops, synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q       <= SCAN_ONES;
      refresh_cnt_q <= '0;
      count_q       <= '0;
      count_p_q     <= '0;
      cap_valid_q   <= 1'b0;
      prev_valid_q  <= 1'b0;
      carry_q       <= 1'b0;
      borrow_q      <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
    end else begin
      state_q       <= state_d;
      refresh_cnt_q <= refresh_cnt_d;
      count_q       <= count_d;
      count_p_q     <= count_p_d;
      cap_valid_q   <= cap_valid_d;
      prev_valid_q  <= prev_valid_d;
      carry_q       <= carry_d;
      borrow_q      <= borrow_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  // Next-state logic for the scan FSM, capture pipeline and wrap detection.
  // prev_valid only rises once count_p holds a captured value, so the reset
  // value of count_q can never pair with the first capture to fake a wrap.
  always_comb begin
    refresh_cnt_d = (refresh_cnt_q == CNT_MAX) ? '0 : refresh_cnt_q + 1'b1;
    state_d       = state_q;
    if (refresh_cnt_q == CNT_MAX) begin
      state_d = (state_q == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
    end
    count_d      = Count;
    count_p_d    = count_q;
    cap_valid_d  = 1'b1;
    prev_valid_d = cap_valid_q;
    carry_d      = prev_valid_q && (count_p_q == 4'd11) && (count_q == 4'd0);
    borrow_d     = prev_valid_q && (count_p_q == 4'd0) && (count_q == 4'd11);
  end

  // Output logic: digit select and segment pattern for the current scan state.
  always_comb begin
    seg_raw = 7'b0000000;
    an_raw  = 2'b00;
    if (cap_valid_q) begin
      if (state_q == SCAN_ONES) begin
        an_raw  = 2'b01;
        seg_raw = err ? SEG_E : seg_encode(ones);
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (tens || err) begin
          an_raw  = 2'b10;
          seg_raw = err ? SEG_E : seg_encode({3'b000, tens});
        end
`else
        an_raw  = 2'b10;
        seg_raw = err ? SEG_E : seg_encode({3'b000, tens});
`endif
      end
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = SEG_ACTIVE_LOW ? ~an_raw : an_raw;
  end

  assign Seg    = seg_q;
  assign An     = an_q;
  assign Carry  = carry_q;
  assign Borrow = borrow_q;
  assign Err    = err;

endmodule

// File: tb/tb_mod12_seg_scan.sv
// tb/tb_mod12_seg_scan.sv - directed self-checking bench for mod12_seg_scan.
module tb_mod12_seg_scan;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Count = 4'd0;
  logic [6:0] Seg;
  logic [1:0] An;
  logic       Carry, Borrow, Err;

  int vectors = 0;
  int miscompares = 0;

  // Active-low expected segment patterns.
  localparam logic [6:0] L0   = 7'b1000000;
  localparam logic [6:0] L1   = 7'b1111001;
  localparam logic [6:0] L5   = 7'b0010010;
  localparam logic [6:0] LE   = 7'b0000110;
  localparam logic [6:0] LOFF = 7'b1111111;
  localparam logic [1:0] A_ONES = 2'b10;
  localparam logic [1:0] A_TENS = 2'b01;
  localparam logic [1:0] A_OFF  = 2'b11;

  mod12_seg_scan #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .Clk(Clk), .reset(reset), .Count(Count),
    .Seg(Seg), .An(An), .Carry(Carry), .Borrow(Borrow), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Count = 4'd5;
    repeat (3) step();
    vectors++; if (An !== A_OFF) begin miscompares++; $display("FAIL reset_an got=%b exp=%b", An, A_OFF); end
    vectors++; if (Seg !== LOFF) begin miscompares++; $display("FAIL reset_seg got=%b exp=%b", Seg, LOFF); end
    vectors++; if ({Carry, Borrow, Err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {Carry, Borrow, Err}); end
  endtask

  task automatic test_scan();
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    do_reset();
    Count = 4'd5;
    step();
    vectors++; if (An !== A_OFF) begin miscompares++; $display("FAIL scan_first_an got=%b exp=%b", An, A_OFF); end
    vectors++; if (Seg !== LOFF) begin miscompares++; $display("FAIL scan_first_seg got=%b exp=%b", Seg, LOFF); end
    for (int n = 2; n <= 13; n++) begin
      step();
      if (((n - 1) / 4) % 2 == 0) begin
        exp_an = A_ONES; exp_seg = L5;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        exp_an = A_OFF; exp_seg = LOFF;
`else
        exp_an = A_TENS; exp_seg = L0;
`endif
      end
      vectors++; if (An !== exp_an) begin miscompares++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", n, An, exp_an); end
      vectors++; if (Seg !== exp_seg) begin miscompares++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", n, Seg, exp_seg); end
    end
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL scan_err got=%b exp=0", Err); end
  endtask

  task automatic test_carry();
    do_reset();
    Count = 4'd9;
    repeat (4) step();
    Count = 4'd10; step();
    Count = 4'd11; step();
    vectors++; if (An !== A_TENS || Seg !== L1) begin miscompares++; $display("FAIL carry_tens10 got=%b/%b exp=%b/%b", An, Seg, A_TENS, L1); end
    Count = 4'd0; step();
    vectors++; if (An !== A_TENS || Seg !== L1) begin miscompares++; $display("FAIL carry_tens11 got=%b/%b exp=%b/%b", An, Seg, A_TENS, L1); end
    vectors++; if (Carry !== 1'b0) begin miscompares++; $display("FAIL carry_early got=%b exp=0", Carry); end
    step();
    vectors++; if (Carry !== 1'b1) begin miscompares++; $display("FAIL carry_pulse got=%b exp=1", Carry); end
    vectors++; if (Borrow !== 1'b0) begin miscompares++; $display("FAIL carry_noborrow got=%b exp=0", Borrow); end
    step();
    vectors++; if (Carry !== 1'b0) begin miscompares++; $display("FAIL carry_width got=%b exp=0", Carry); end
  endtask

  task automatic test_borrow();
    do_reset();
    Count = 4'd1; step(); step();
    Count = 4'd0; step();
    Count = 4'd11; step();
    vectors++; if (Borrow !== 1'b0) begin miscompares++; $display("FAIL borrow_early got=%b exp=0", Borrow); end
    vectors++; if (An !== A_ONES || Seg !== L0) begin miscompares++; $display("FAIL borrow_ones0 got=%b/%b exp=%b/%b", An, Seg, A_ONES, L0); end
    step();
    vectors++; if (Borrow !== 1'b1) begin miscompares++; $display("FAIL borrow_pulse got=%b exp=1", Borrow); end
    vectors++; if (Carry !== 1'b0) begin miscompares++; $display("FAIL borrow_nocarry got=%b exp=0", Carry); end
    vectors++; if (An !== A_TENS || Seg !== L1) begin miscompares++; $display("FAIL borrow_tens11 got=%b/%b exp=%b/%b", An, Seg, A_TENS, L1); end
    step();
    vectors++; if (Borrow !== 1'b0) begin miscompares++; $display("FAIL borrow_width got=%b exp=0", Borrow); end
  endtask

  task automatic test_err();
    do_reset();
    Count = 4'd13; step();
    vectors++; if (Err !== 1'b1) begin miscompares++; $display("FAIL err_set got=%b exp=1", Err); end
    step();
    vectors++; if (An !== A_ONES || Seg !== LE) begin miscompares++; $display("FAIL err_ones got=%b/%b exp=%b/%b", An, Seg, A_ONES, LE); end
    step(); step(); step();
    vectors++; if (An !== A_TENS || Seg !== LE) begin miscompares++; $display("FAIL err_tens got=%b/%b exp=%b/%b", An, Seg, A_TENS, LE); end
    Count = 4'd0; step();
    vectors++; if (Err !== 1'b0) begin miscompares++; $display("FAIL err_clear got=%b exp=0", Err); end
    step();
    vectors++; if (Carry !== 1'b0) begin miscompares++; $display("FAIL err_nocarry got=%b exp=0", Carry); end
    step();
    vectors++; if (Carry !== 1'b0) begin miscompares++; $display("FAIL err_nocarry2 got=%b exp=0", Carry); end
  endtask

  task automatic test_first_after_reset();
    Count = 4'd11;
    do_reset();
    Count = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({Carry, Borrow} !== 2'b00) begin miscompares++; $display("FAIL first_nowrap cyc=%0d got=%b exp=00", i, {Carry, Borrow}); end
    end
    Count = 4'd0;
    do_reset();
    Count = 4'd11;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({Carry, Borrow} !== 2'b00) begin miscompares++; $display("FAIL first_noborrow cyc=%0d got=%b exp=00", i, {Carry, Borrow}); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Count = 4'd11; step(); step();
    Count = 4'd0; step();
    reset = 1'b1; step();
    vectors++; if (An !== A_OFF || Seg !== LOFF) begin miscompares++; $display("FAIL mid_disp got=%b/%b exp=%b/%b", An, Seg, A_OFF, LOFF); end
    vectors++; if ({Carry, Borrow, Err} !== 3'b000) begin miscompares++; $display("FAIL mid_flags got=%b exp=000", {Carry, Borrow, Err}); end
    reset = 1'b0;
    Count = 4'd14; step(); step();
    vectors++; if (Err !== 1'b1) begin miscompares++; $display("FAIL mid_err_pre got=%b exp=1", Err); end
    reset = 1'b1; step();
    vectors++; if ({Carry, Borrow, Err} !== 3'b000 || An !== A_OFF || Seg !== LOFF) begin miscompares++; $display("FAIL mid_err_reset got=%b %b %b exp=000 %b %b", {Carry, Borrow, Err}, An, Seg, A_OFF, LOFF); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    Count = 4'd11; step(); step();
    Count = 4'd0;  step();
    Count = 4'd11; step();
    vectors++; if ({Carry, Borrow} !== 2'b10) begin miscompares++; $display("FAIL b2b_carry got=%b exp=10", {Carry, Borrow}); end
    Count = 4'd0; step();
    vectors++; if ({Carry, Borrow} !== 2'b01) begin miscompares++; $display("FAIL b2b_borrow got=%b exp=01", {Carry, Borrow}); end
    step();
    vectors++; if ({Carry, Borrow} !== 2'b10) begin miscompares++; $display("FAIL b2b_carry2 got=%b exp=10", {Carry, Borrow}); end
    step();
    vectors++; if ({Carry, Borrow} !== 2'b00) begin miscompares++; $display("FAIL b2b_hold got=%b exp=00", {Carry, Borrow}); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_carry();
    test_borrow();
    test_err();
    test_first_after_reset();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
